// File: rtl/seq_tx.sv
// seq_tx: nibble FIFO that transmits a queued frame downstream, then waits for a result bit or times out
module seq_tx #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [3:0]               wr_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     start,
    output logic                     busy,
    output logic                     in_valid,
    output logic [3:0]               in_data,
    input  logic                     out_valid,
    input  logic                     out_data,
    output logic                     done,
    output logic                     result,
    output logic                     timeout
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

    state_t          state_q, state_d;
    logic [3:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d, left_q, left_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic            full_q, full_d, busy_q, busy_d;
    logic            in_valid_q, in_valid_d;
    logic [3:0]      in_data_q, in_data_d;
    logic            done_q, done_d, result_q, result_d, timeout_q, timeout_d;
    logic            push, pop;

    // next-state, FIFO bookkeeping and registered-output values
    always_comb begin
        state_d    = state_q;
        left_d     = left_q;
        tcnt_d     = tcnt_q;
        result_d   = result_q;
        done_d     = 1'b0;
        timeout_d  = 1'b0;
        in_valid_d = 1'b0;
        in_data_d  = 4'd0;
        pop        = 1'b0;
        push       = wr_en && count_q != CW'(DEPTH) && state_q == IDLE;
        case (state_q)
            IDLE: begin
                if (start && count_q != '0) begin
                    state_d = SEND;
                    pop     = 1'b1;
                    left_d  = count_q - CW'(1);
                end
            end
            SEND: begin
                if (left_q != '0) begin
                    pop    = 1'b1;
                    left_d = left_q - CW'(1);
                end else begin
                    state_d = WAIT;
                    tcnt_d  = '0;
                end
            end
            WAIT: begin
                if (out_valid) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    result_d = out_data;
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    result_d  = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            in_valid_d = 1'b1;
            in_data_d  = mem_q[rd_ptr_q];
        end
        rd_ptr_d = rd_ptr_q + AW'(pop);
        wr_ptr_d = wr_ptr_q + AW'(push);
        count_d  = count_q + CW'(push) - CW'(pop);
        full_d   = count_d == CW'(DEPTH);
        busy_d   = state_d == SEND || state_d == WAIT;
    end

    // FIFO storage; pointers are reset instead of contents
    always_ff @(posedge clk) begin
        if (!rst && push) mem_q[wr_ptr_q] <= wr_data;
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            left_q     <= '0;
            tcnt_q     <= '0;
            full_q     <= 1'b0;
            busy_q     <= 1'b0;
            in_valid_q <= 1'b0;
            in_data_q  <= 4'd0;
            done_q     <= 1'b0;
            result_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            left_q     <= left_d;
            tcnt_q     <= tcnt_d;
            full_q     <= full_d;
            busy_q     <= busy_d;
            in_valid_q <= in_valid_d;
            in_data_q  <= in_data_d;
            done_q     <= done_d;
            result_q   <= result_d;
            timeout_q  <= timeout_d;
        end
    end

    assign full     = full_q;
    assign count    = count_q;
    assign busy     = busy_q;
    assign in_valid = in_valid_q;
    assign in_data  = in_data_q;
    assign done     = done_q;
    assign result   = result_q;
    assign timeout  = timeout_q;
endmodule

// File: tb/tb_seq_tx.sv
// tb_seq_tx: randomized scoreboard bench for seq_tx against a queue-based frame model
module tb_seq_tx;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [3:0] wr_data = 4'd0;
    logic       full;
    logic [3:0] count;
    logic       start = 1'b0;
    logic       busy;
    logic       in_valid;
    logic [3:0] in_data;
    logic       out_valid = 1'b0;
    logic       out_data = 1'b0;
    logic       done;
    logic       result;
    logic       timeout;

    int         vectors = 0;
    int         errs = 0;
    bit         mon_en = 1'b0;
    logic [3:0] model[$];
    logic [3:0] exp_nib[$];
    logic [1:0] exp_done[$];

    seq_tx #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
        .count(count), .start(start), .busy(busy), .in_valid(in_valid),
        .in_data(in_data), .out_valid(out_valid), .out_data(out_data),
        .done(done), .result(result), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: pops expected nibbles and completion records as the DUT presents them
    always @(negedge clk) begin
        if (mon_en) begin
            if (in_valid) begin
                if (exp_nib.size() == 0) chk("in_valid_unexpected", int'(in_valid), 0);
                else chk("in_data", int'(in_data), int'(exp_nib.pop_front()));
            end else begin
                chk("in_data_idle", int'(in_data), 0);
            end
            if (done) begin
                if (exp_done.size() == 0) chk("done_unexpected", int'(done), 0);
                else begin
                    logic [1:0] e;
                    e = exp_done.pop_front();
                    chk("result", int'(result), int'(e[1]));
                    chk("timeout", int'(timeout), int'(e[0]));
                end
            end else begin
                chk("timeout_without_done", int'(timeout), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] d);
        wr_en = 1'b1;
        wr_data = d;
        tick();
        wr_en = 1'b0;
        if (model.size() < DEPTH) model.push_back(d);
        chk("count", int'(count), model.size());
        chk("full", int'(full), int'(model.size() == DEPTH));
    endtask

    task automatic frame(input bit resp, input int j, input bit b, input bit junk);
        int n;
        n = model.size();
        foreach (model[i]) exp_nib.push_back(model[i]);
        model.delete();
        if (!resp) exp_done.push_back(2'b01);
        start = 1'b1;
        tick();
        start = junk;
        wr_en = junk;
        wr_data = 4'($urandom);
        out_valid = junk;
        out_data = 1'b1;
        chk("busy_send", int'(busy), 1);
        chk("in_valid_first", int'(in_valid), 1);
        repeat (n) tick();
        start = 1'b0;
        wr_en = 1'b0;
        out_valid = 1'b0;
        chk("in_valid_end", int'(in_valid), 0);
        chk("busy_wait", int'(busy), 1);
        chk("frame_len", exp_nib.size(), 0);
        if (resp) begin
            repeat (j) tick();
            out_valid = 1'b1;
            out_data = b;
            exp_done.push_back({b, 1'b0});
            tick();
            out_valid = 1'b0;
            chk("done_after_resp", int'(done), 1);
        end else begin
            repeat (TIMEOUT - 1) tick();
            chk("done_early", int'(done), 0);
            tick();
            chk("done_at_timeout", int'(done), 1);
        end
        tick();
        chk("done_one_cycle", int'(done), 0);
        chk("result_hold", int'(result), int'(resp && b));
        chk("busy_idle", int'(busy), 0);
        chk("count_after", int'(count), model.size());
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_count", int'(count), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_valid", int'(in_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_result", int'(result), 0);
        rst = 1'b0;
        mon_en = 1'b1;
        tick();
        wr(4'h3); wr(4'hA); wr(4'h5);
        frame(1'b1, 1, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) wr(4'(i + 7));
        frame(1'b1, 0, 1'b0, 1'b0);
        wr(4'h6); wr(4'hC);
        frame(1'b0, 0, 1'b0, 1'b0);
        wr(4'h1); wr(4'hE);
        frame(1'b1, TIMEOUT - 1, 1'b1, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("empty_start_busy", int'(busy), 0);
        chk("empty_start_count", int'(count), 0);
        wr(4'h2); wr(4'h4);
        frame(1'b1, 2, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) wr(4'(4'hB - i));
        exp_nib.push_back(model[0]);
        exp_nib.push_back(model[1]);
        model.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_in_valid", int'(in_valid), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_count", int'(count), 0);
        chk("rst_mid_result", int'(result), 0);
        chk("rst_mid_leftover", exp_nib.size(), 0);
        wr(4'h9); wr(4'h0); wr(4'hF);
        frame(1'b1, 3, 1'b1, 1'b0);
        for (int it = 0; it < 40; it++) begin
            int k;
            k = $urandom_range(1, DEPTH + 2);
            for (int i = 0; i < k; i++) wr(4'($urandom));
            frame($urandom_range(0, 3) != 0, $urandom_range(0, TIMEOUT - 1),
                  1'($urandom), 1'($urandom));
        end
        chk("final_nib_queue", exp_nib.size(), 0);
        chk("final_done_queue", exp_done.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
